// File: rtl/spi_fifo_wm.sv
// spi_fifo_wm: SPI TX/RX FIFO with req/ack write port and req/resp/ack read port.
// Power-of-two depth, same-cycle push+pop, optional overwrite of the oldest
// entry when full, sticky overflow/underflow flags.
// Optional feature macro: SPI_FIFO_WATERMARK_EN adds almost-full/almost-empty
// watermark inputs and registered outputs.
module spi_fifo_wm #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_ADDR  = 4,
    parameter int REG_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  soft_rst_i,
    input  logic                  allow_overwrite_i,
    input  logic                  clear_flags_i,
    input  logic                  req_a_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    output logic                  ack_a_o,
    input  logic                  req_b_i,
    output logic [DATA_WIDTH-1:0] data_b_o,
    output logic                  resp_b_o,
    input  logic                  ack_b_i,
    output logic [REG_WIDTH-1:0]  fifo_occupancy_o,
    output logic                  fifo_full_o,
    output logic                  fifo_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
`ifdef SPI_FIFO_WATERMARK_EN
    ,
    input  logic [FIFO_ADDR:0]    afull_thr_i,
    input  logic [FIFO_ADDR:0]    aempty_thr_i,
    output logic                  almost_full_o,
    output logic                  almost_empty_o
`endif
);

    localparam int DEPTH = 2 ** FIFO_ADDR;
    // Occupancy value meaning "full": only the MSB of the count set.
    localparam logic [FIFO_ADDR:0] C_OCC_FULL = {1'b1, {FIFO_ADDR{1'b0}}};

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_ACK  = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

    // State registers and their next-state values
    wr_state_t             r_wr_state;
    wr_state_t             w_wr_state_next;
    rd_state_t             r_rd_state;
    rd_state_t             w_rd_state_next;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [FIFO_ADDR-1:0]  r_head;
    logic [FIFO_ADDR-1:0]  r_tail;
    logic [FIFO_ADDR-1:0]  w_head_next;
    logic [FIFO_ADDR-1:0]  w_tail_next;
    logic [FIFO_ADDR:0]    r_occ;
    logic [FIFO_ADDR:0]    w_occ_next;

    logic                  r_pend;
    logic                  w_pend_next;
    logic                  r_ack_a;
    logic                  w_ack_a_next;
    logic                  r_resp_b;
    logic                  w_resp_b_next;
    logic [DATA_WIDTH-1:0] r_data_b;
    logic                  r_overflow;
    logic                  w_overflow_next;
    logic                  r_underflow;
    logic                  w_underflow_next;

    // Event decodes
    logic                  w_rst;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_overwrite;
    logic                  w_rd_start;
    logic                  w_rd_start_valid;
    logic                  w_rd_hold;
    logic                  w_wr_room;

    assign w_rst   = ~rst_n_i | soft_rst_i;
    assign w_full  = (r_occ == C_OCC_FULL);
    assign w_empty = (r_occ == '0);

    // A read request seen in IDLE starts a response this edge.
    assign w_rd_start       = (r_rd_state == RD_IDLE) && req_b_i;
    assign w_rd_start_valid = w_rd_start && !w_empty;
    // Pop only happens on ack of a response that carries real data.
    assign w_pop            = (r_rd_state == RD_RESP) && ack_b_i && r_pend;
    // The head entry is (or is about to be) presented to the reader; it must
    // not be discarded by an overwrite while that is the case.
    assign w_rd_hold        = ((r_rd_state == RD_RESP) && r_pend) || w_rd_start_valid;
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign w_wr_room        = !w_full || w_pop || (allow_overwrite_i && !w_rd_hold);
    assign w_overwrite      = w_push && w_full && !w_pop;

    // Write FSM: accept a write in IDLE, pulse ack for one cycle in ACK.
    always_comb begin
        w_wr_state_next = r_wr_state;
        w_ack_a_next    = 1'b0;
        w_push          = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (req_a_i && w_wr_room) begin
                    w_push          = 1'b1;
                    w_ack_a_next    = 1'b1;
                    w_wr_state_next = WR_ACK;
                end
            end
            WR_ACK: begin
                w_wr_state_next = WR_IDLE;
            end
            default: begin
                w_wr_state_next = WR_IDLE;
            end
        endcase
    end

    // Read FSM: raise resp on request, hold it until the consumer acknowledges.
    always_comb begin
        w_rd_state_next = r_rd_state;
        w_resp_b_next   = r_resp_b;
        w_pend_next     = r_pend;
        case (r_rd_state)
            RD_IDLE: begin
                if (req_b_i) begin
                    w_rd_state_next = RD_RESP;
                    w_resp_b_next   = 1'b1;
                    w_pend_next     = !w_empty;
                end
            end
            RD_RESP: begin
                if (ack_b_i) begin
                    w_rd_state_next = RD_IDLE;
                    w_resp_b_next   = 1'b0;
                    w_pend_next     = 1'b0;
                end
            end
            default: begin
                w_rd_state_next = RD_IDLE;
            end
        endcase
    end

    // Pointer and occupancy arithmetic; pointers wrap naturally at DEPTH.
    always_comb begin
        w_tail_next = r_tail;
        w_head_next = r_head;
        w_occ_next  = r_occ;
        if (w_push) begin
            w_tail_next = r_tail + 1'b1;
        end
        if (w_pop || w_overwrite) begin
            w_head_next = r_head + 1'b1;
        end
        if (w_rst) begin
            w_occ_next = '0;
        end else if (w_push && !w_pop && !w_overwrite) begin
            w_occ_next = r_occ + 1'b1;
        end else if (w_pop && !w_push) begin
            w_occ_next = r_occ - 1'b1;
        end
    end

    // Sticky flags: clear request first, a coincident set event overrides it.
    always_comb begin
        w_overflow_next  = r_overflow;
        w_underflow_next = r_underflow;
        if (clear_flags_i) begin
            w_overflow_next  = 1'b0;
            w_underflow_next = 1'b0;
        end
        if (w_overwrite) begin
            w_overflow_next = 1'b1;
        end
        if (w_rd_start && w_empty) begin
            w_underflow_next = 1'b1;
        end
    end

    // Control state registers; hard or soft reset overrides every event.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || soft_rst_i) begin
            r_wr_state  <= WR_IDLE;
            r_rd_state  <= RD_IDLE;
            r_head      <= '0;
            r_tail      <= '0;
            r_occ       <= '0;
            r_pend      <= 1'b0;
            r_ack_a     <= 1'b0;
            r_resp_b    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_state  <= w_wr_state_next;
            r_rd_state  <= w_rd_state_next;
            r_head      <= w_head_next;
            r_tail      <= w_tail_next;
            r_occ       <= w_occ_next;
            r_pend      <= w_pend_next;
            r_ack_a     <= w_ack_a_next;
            r_resp_b    <= w_resp_b_next;
            r_overflow  <= w_overflow_next;
            r_underflow <= w_underflow_next;
        end
    end

    // Read data register: captures the head entry, or zero on an empty read.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || soft_rst_i) begin
            r_data_b <= '0;
        end else if (w_rd_start_valid) begin
            r_data_b <= r_mem[r_head];
        end else if (w_rd_start) begin
            r_data_b <= '0;
        end
    end

    // Storage array; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && !soft_rst_i && w_push) begin
            r_mem[r_tail] <= data_a_i;
        end
    end

`ifdef SPI_FIFO_WATERMARK_EN
    logic r_almost_full;
    logic r_almost_empty;

    // Watermarks track the occupancy that will hold after this edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || soft_rst_i) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_occ_next >= afull_thr_i);
            r_almost_empty <= (w_occ_next <= aempty_thr_i);
        end
    end

    assign almost_full_o  = r_almost_full;
    assign almost_empty_o = r_almost_empty;
`endif

    assign ack_a_o          = r_ack_a;
    assign resp_b_o         = r_resp_b;
    assign data_b_o         = r_data_b;
    assign fifo_occupancy_o = REG_WIDTH'(r_occ);
    assign fifo_full_o      = w_full;
    assign fifo_empty_o     = w_empty;
    assign overflow_o       = r_overflow;
    assign underflow_o      = r_underflow;

endmodule

// File: tb/tb_spi_fifo_wm.sv
// Testbench for spi_fifo_wm: table of write/read vectors with expected status,
// a queue scoreboard of expected read data, and hand sequences for same-edge
// push+pop, wrap-around and soft reset during a response.
module tb_spi_fifo_wm;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int RW    = 16;
    localparam int DEPTH = 16;
    localparam int NV    = 35;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          soft_rst   = 1'b0;
    logic          allow_ovw  = 1'b0;
    logic          clear_flg  = 1'b0;
    logic          req_a      = 1'b0;
    logic [DW-1:0] data_a     = '0;
    logic          ack_a;
    logic          req_b      = 1'b0;
    logic [DW-1:0] data_b;
    logic          resp_b;
    logic          ack_b      = 1'b0;
    logic [RW-1:0] occ;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;
`ifdef SPI_FIFO_WATERMARK_EN
    logic [AW:0]   afull_thr  = 5'd12;
    logic [AW:0]   aempty_thr = 5'd2;
    logic          almost_full;
    logic          almost_empty;
`endif

    always #5 clk = ~clk;

    spi_fifo_wm #(
        .DATA_WIDTH (DW),
        .FIFO_ADDR  (AW),
        .REG_WIDTH  (RW)
    ) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .soft_rst_i        (soft_rst),
        .allow_overwrite_i (allow_ovw),
        .clear_flags_i     (clear_flg),
        .req_a_i           (req_a),
        .data_a_i          (data_a),
        .ack_a_o           (ack_a),
        .req_b_i           (req_b),
        .data_b_o          (data_b),
        .resp_b_o          (resp_b),
        .ack_b_i           (ack_b),
        .fifo_occupancy_o  (occ),
        .fifo_full_o       (full),
        .fifo_empty_o      (empty),
        .overflow_o        (ovf),
        .underflow_o       (unf)
`ifdef SPI_FIFO_WATERMARK_EN
        ,
        .afull_thr_i       (afull_thr),
        .aempty_thr_i      (aempty_thr),
        .almost_full_o     (almost_full),
        .almost_empty_o    (almost_empty)
`endif
    );

    typedef struct {
        logic        is_wr;
        logic [15:0] wdata;
        logic        ovw;
        logic        exp_hs;     // write acked / read responded
        logic [4:0]  exp_occ;
        logic        exp_full;
        logic        exp_empty;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    vec_t        vecs [NV];
    logic [15:0] sb [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic [4:0] e_occ, input logic e_full,
                                input logic e_empty, input logic e_ovf, input logic e_unf);
        check({tag, "_occ"},   occ,   32'(e_occ));
        check({tag, "_full"},  full,  e_full);
        check({tag, "_empty"}, empty, e_empty);
        check({tag, "_ovf"},   ovf,   e_ovf);
        check({tag, "_unf"},   unf,   e_unf);
    endtask

    // One write transaction; waits a bounded number of cycles for ack.
    task automatic write_op(input logic [15:0] d, input logic ovw, output logic got);
        @(negedge clk);
        data_a    = d;
        allow_ovw = ovw;
        req_a     = 1'b1;
        got       = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack_a) begin
                got = 1'b1;
                break;
            end
        end
        req_a     = 1'b0;
        allow_ovw = 1'b0;
        $display("[%0t] WR data=%h ovw=%b ack=%b occ=%0d", $time, d, ovw, got, occ);
    endtask

    // One read transaction: request, capture response, acknowledge.
    task automatic read_op(output logic [15:0] d, output logic got);
        @(negedge clk);
        req_b = 1'b1;
        got   = 1'b0;
        d     = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_b) begin
                got = 1'b1;
                d   = data_b;
                break;
            end
        end
        req_b = 1'b0;
        if (got) begin
            ack_b = 1'b1;
            @(negedge clk);
            ack_b = 1'b0;
            check("resp_drop", resp_b, 1'b0);
        end
        $display("[%0t] RD data=%h resp=%b occ=%0d", $time, d, got, occ);
    endtask

    task automatic sb_read(input string tag);
        logic [15:0] d;
        logic        got;
        logic [15:0] exp_d;
        exp_d = (sb.size() > 0) ? sb.pop_front() : 16'h0000;
        read_op(d, got);
        check({tag, "_resp"}, got, 1'b1);
        check({tag, "_data"}, d, exp_d);
    endtask

    task automatic sb_write(input string tag, input logic [15:0] d);
        logic got;
        sb.push_back(d);
        write_op(d, 1'b0, got);
        check({tag, "_ack"}, got, 1'b1);
    endtask

    initial begin
        logic        got;
        logic [15:0] d;
        logic [15:0] exp_d;

        // ---------------- vector table ----------------
        for (int i = 0; i < 16; i++)
            vecs[i] = '{1'b1, 16'(i), 1'b0, 1'b1, 5'(i + 1), (i == 15), 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 16'h5555, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 16'hAAAA, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 16; k++)
            vecs[18 + k] = '{1'b0, 16'h0000, 1'b0, 1'b1, 5'(15 - k), 1'b0, (k == 15), 1'b1, 1'b0};
        vecs[34] = '{1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1};

        // ---------------- reset (requests asserted, reset must win) ----------------
        rst_n = 1'b0;
        req_a = 1'b1;
        req_b = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ack", ack_a, 1'b0);
        check("rst_resp", resp_b, 1'b0);
        check("rst_data", data_b, 16'h0000);
        check_status("rst", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table: fill, stall, overwrite, drain, empty read ----------------
        for (int v = 0; v < NV; v++) begin
            if (vecs[v].is_wr) begin
                if (vecs[v].exp_hs) begin
                    if (sb.size() == DEPTH) void'(sb.pop_front());
                    sb.push_back(vecs[v].wdata);
                end
                write_op(vecs[v].wdata, vecs[v].ovw, got);
                check($sformatf("v%0d_ack", v), got, vecs[v].exp_hs);
            end else begin
                exp_d = (sb.size() > 0) ? sb.pop_front() : 16'h0000;
                read_op(d, got);
                check($sformatf("v%0d_resp", v), got, vecs[v].exp_hs);
                check($sformatf("v%0d_data", v), d, exp_d);
            end
            check_status($sformatf("v%0d", v), vecs[v].exp_occ, vecs[v].exp_full,
                         vecs[v].exp_empty, vecs[v].exp_ovf, vecs[v].exp_unf);
        end

        // ---------------- clear sticky flags ----------------
        @(negedge clk);
        clear_flg = 1'b1;
        @(negedge clk);
        clear_flg = 1'b0;
        check("clr_ovf", ovf, 1'b0);
        check("clr_unf", unf, 1'b0);

        // ---------------- same-edge push+pop at occupancy 5 ----------------
        for (int i = 0; i < 5; i++) sb_write("sim_fill", 16'h0100 + 16'(i));
        check("sim_occ0", occ, 16'd5);
        @(negedge clk);
        req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        exp_d = sb.pop_front();
        check("sim_resp", resp_b, 1'b1);
        check("sim_data", data_b, exp_d);
        ack_b  = 1'b1;
        req_a  = 1'b1;
        data_a = 16'h1234;
        sb.push_back(16'h1234);
        @(negedge clk);
        ack_b = 1'b0;
        req_a = 1'b0;
        check("sim_ack", ack_a, 1'b1);
        check("sim_resp_drop", resp_b, 1'b0);
        check("sim_occ", occ, 16'd5);

        // ---------------- same-edge push+pop while full: no overflow ----------------
        for (int i = 0; i < 11; i++) sb_write("fpp_fill", 16'h0200 + 16'(i));
        check("fpp_full", full, 1'b1);
        @(negedge clk);
        req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        exp_d = sb.pop_front();
        check("fpp_resp", resp_b, 1'b1);
        check("fpp_data", data_b, exp_d);
        ack_b  = 1'b1;
        req_a  = 1'b1;
        data_a = 16'hBEEF;
        sb.push_back(16'hBEEF);
        @(negedge clk);
        ack_b = 1'b0;
        req_a = 1'b0;
        check("fpp_ack", ack_a, 1'b1);
        check("fpp_occ", occ, 16'd16);
        check("fpp_ovf", ovf, 1'b0);
        while (sb.size() > 0) sb_read("fpp_drain");
        check_status("fpp_end", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // ---------------- interleaved traffic across pointer wrap ----------------
        for (int i = 0; i < 40; i++) begin
            sb_write("wrap_wr", 16'($urandom));
            if ((i % 4) != 3) sb_read("wrap_rd");
        end
        check("wrap_occ", occ, 16'(sb.size()));
        while (sb.size() > 0) sb_read("wrap_drain");
        check_status("wrap_end", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // ---------------- soft reset while a response is pending ----------------
        sb_write("srst_fill", 16'hC001);
        sb_write("srst_fill", 16'hC002);
        @(negedge clk);
        req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        check("srst_resp", resp_b, 1'b1);
        check("srst_data", data_b, 16'hC001);
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        sb.delete();
        check("srst_resp_drop", resp_b, 1'b0);
        check("srst_dout", data_b, 16'h0000);
        check_status("srst", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        sb_write("post_srst", 16'h0077);
        sb_read("post_srst");
        check("post_srst_occ", occ, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
